// File: rtl/fir_pkg.sv
// Shared FIR datapath constants used by the filter and its output sink.
package fir_pkg;

  localparam int unsigned FIR_IN_W  = 4;
  localparam int unsigned FIR_OUT_W = 8;

endpackage

// File: rtl/fir_sink_fifo.sv
// Synchronous FIFO with level tracking and a registered head-of-queue output.
module fir_sink_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DataW-1:0]         wdata_i,
  output logic [DataW-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [DataW-1:0] rdata_q, rdata_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    // The next head may be the slot being written this cycle; forward it.
    if (level_d == '0) begin
      rdata_d = '0;
    end else if (push_i && (wr_ptr_q == rd_ptr_d)) begin
      rdata_d = wdata_i;
    end else begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;
  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/fir_output_sink.sv
// Receive end of the FIR output stream: FIFO buffering, drop/overflow tracking, counters.
// Optional 1-in-DECIM decimation is compiled in with FIR_SINK_DECIM_EN.
module fir_output_sink
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_OUT_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DECIM  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ovf,
  input  logic                      clr_ovf,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("DECIM must be at least 1");
  end

  logic keep, push, pop, drop, full, empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

`ifdef FIR_SINK_DECIM_EN
  localparam int unsigned PhW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PhW-1:0] phase_q, phase_d;

  // Phase follows every valid input, whether or not the sample is kept or dropped.
  always_comb begin
    phase_d = phase_q;
    if (in_valid) phase_d = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + PhW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign keep = (phase_q == '0);
`else
  assign keep = 1'b1;
`endif

  assign pop  = out_valid & out_ready;
  assign push = in_valid & keep & (~full | pop);
  assign drop = in_valid & keep & full & ~pop;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    ovf_d        = ovf_q;
    drop_cnt_d   = drop_cnt_q;
    if (push) sample_cnt_d = sample_cnt_q + CNT_W'(1);
    // A drop in the same cycle as clr_ovf takes priority over the clear.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)                 drop_cnt_d = CNT_W'(1);
      else if (drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  fir_sink_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_data   = fifo_rdata;
  assign out_valid  = ~empty;
  assign ovf        = ovf_q;
  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fir_output_sink.sv
// Directed, table-driven bench for fir_output_sink (DEPTH=8, CNT_W=16, DECIM=4).
module tb_fir_output_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        clr_ovf;
  logic [15:0] sample_cnt;
  logic [15:0] drop_cnt;
  logic [3:0]  level;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    int         el;
    logic       eo;
    int         edrop;
    int         es;
  } vec_t;

  vec_t vecs[$];

  fir_output_sink #(
    .DATA_W (8),
    .DEPTH  (8),
    .CNT_W  (16),
    .DECIM  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .sample_cnt (sample_cnt),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input int id, input logic ordy, input logic clr,
                     input logic ev, input int ed, input int el, input logic eo,
                     input int edrop, input int es);
    vec_t v;
    v.iv = iv; v.id = 8'(id); v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.ed = 8'(ed); v.el = el; v.eo = eo; v.edrop = edrop; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic check_zero(input int idx);
    cmp("rst_valid", idx, {31'b0, out_valid}, 32'd0);
    cmp("rst_data", idx, {24'b0, out_data}, 32'd0);
    cmp("rst_level", idx, {28'b0, level}, 32'd0);
    cmp("rst_ovf", idx, {31'b0, ovf}, 32'd0);
    cmp("rst_sample", idx, {16'b0, sample_cnt}, 32'd0);
    cmp("rst_drop", idx, {16'b0, drop_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero(0);

    // No bypass: out_valid must stay low until the capturing edge.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55;
    #1 cmp("no_bypass", 0, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    cmp("first_valid", 0, {31'b0, out_valid}, 32'd1);
    cmp("first_data", 0, {24'b0, out_data}, 32'h55);
    @(negedge clk); in_data = 8'h66;
    @(negedge clk); in_data = 8'h77;
    @(negedge clk); in_valid = 1'b0;
    cmp("pre_rst_level", 0, {28'b0, level}, 32'd3);
    // Asynchronous reset mid-stream, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FIR_SINK_DECIM_EN
    begin
      logic [7:0] exp_out [4];
      exp_out[0] = 8'hF8; exp_out[1] = 8'hFC; exp_out[2] = 8'h00; exp_out[3] = 8'h04;
      for (int k = -8; k < 8; k++) begin
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'(k);
      end
      @(negedge clk);
      in_valid = 1'b0;
      cmp("decim_sample", 0, {16'b0, sample_cnt}, 32'd4);
      cmp("decim_level", 0, {28'b0, level}, 32'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        #1;
        cmp("decim_valid", k, {31'b0, out_valid}, 32'd1);
        cmp("decim_data", k, {24'b0, out_data}, {24'b0, exp_out[k]});
        @(negedge clk);
      end
      cmp("decim_empty", 0, {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;
    end
`else
    // Pass-through with out_ready held high.
    for (int k = 1; k <= 8; k++) add(1, k, 1, 0, 1, k, 1, 0, 0, k);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 8);
    // Overflow: ten pushes into an eight-entry FIFO with the consumer stalled.
    for (int i = 1; i <= 10; i++)
      add(1, i, 0, 0, 1, 1, (i > 8) ? 8 : i, i > 8, (i > 8) ? i - 8 : 0,
          8 + ((i > 8) ? 8 : i));
    for (int j = 1; j <= 8; j++) add(0, 0, 1, 0, j < 8, j + 1, 8 - j, 1, 2, 16);
    // Refill, then push and pop together while full.
    for (int i = 1; i <= 8; i++) add(1, 20 + i, 0, 0, 1, 21, i, 1, 2, 16 + i);
    add(1, 29, 1, 0, 1, 22, 8, 1, 2, 25);
    // clr_ovf alone, then clr_ovf coinciding with a drop, then a plain drop.
    add(0, 0, 0, 1, 1, 22, 8, 0, 0, 25);
    add(1, 30, 0, 1, 1, 22, 8, 1, 1, 25);
    add(1, 31, 0, 0, 1, 22, 8, 1, 2, 25);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_data = vecs[i].id;
      out_ready = vecs[i].ordy; clr_ovf = vecs[i].clr;
      @(posedge clk); #1;
      cmp("out_valid", i, {31'b0, out_valid}, {31'b0, vecs[i].ev});
      if (vecs[i].ev) cmp("out_data", i, {24'b0, out_data}, {24'b0, vecs[i].ed});
      cmp("level", i, {28'b0, level}, vecs[i].el);
      cmp("ovf", i, {31'b0, ovf}, {31'b0, vecs[i].eo});
      cmp("drop_cnt", i, {16'b0, drop_cnt}, vecs[i].edrop);
      cmp("sample_cnt", i, {16'b0, sample_cnt}, vecs[i].es);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
`endif

    do_reset();
    #1 check_zero(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
